// File: rtl/wishbone_classic_cmd_controller.sv
// Wishbone classic command controller: one valid/ready command becomes one
// single read/write bus cycle, with bounded retry on rty_i and a per-attempt
// timeout. The result returns on a valid/ready response stream with a status.
module wishbone_classic_cmd_controller #(
    parameter int ADR_WIDTH      = 32,
    parameter int DAT_WIDTH      = 32,
    parameter int MAX_RETRIES    = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_we,
    input  logic [ADR_WIDTH-1:0]   cmd_adr,
    input  logic [DAT_WIDTH-1:0]   cmd_dat,
    input  logic [DAT_WIDTH/8-1:0] cmd_sel,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DAT_WIDTH-1:0]   rsp_dat,
    output logic [1:0]             rsp_status,
    output logic                   cyc_o,
    output logic                   stb_o,
    output logic                   we_o,
    output logic [ADR_WIDTH-1:0]   adr_o,
    output logic [DAT_WIDTH-1:0]   dat_o,
    output logic [DAT_WIDTH/8-1:0] sel_o,
    input  logic [DAT_WIDTH-1:0]   dat_i,
    input  logic                   ack_i,
    input  logic                   err_i,
    input  logic                   rty_i
);
    localparam int SEL_W = DAT_WIDTH / 8;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    // A zero-retry build still needs a 1-bit counter to stay legal.
    localparam int RW    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_BACKOFF, S_RESP} state_e;

    state_e               state_q, state_d;
    logic                 cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [ADR_WIDTH-1:0] adr_q, adr_d;
    logic [DAT_WIDTH-1:0] dat_q, dat_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DAT_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]           rsp_status_q, rsp_status_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [RW-1:0]        rty_q, rty_d;

    // State and every registered output; reset drops any bus cycle at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            sel_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= ST_OK;
            tmo_q        <= '0;
            rty_q        <= '0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            tmo_q        <= tmo_d;
            rty_q        <= rty_d;
        end
    end

    // Next-state and output decode; terminations priority err > ack > rty > timeout.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        tmo_d        = tmo_q;
        rty_d        = rty_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    rty_d   = '0;
                    tmo_d   = '0;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
                if (err_i || ack_i || (rty_i && rty_q == RTY_MAX) || (!rty_i && tmo_q == TMO_LAST)) begin
                    // Any terminal outcome: close the cycle and present a response.
                    cyc_d        = 1'b0;
                    stb_d        = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_dat_d    = '0;
                    state_d      = S_RESP;
                    if (err_i)      rsp_status_d = ST_ERR;
                    else if (ack_i) begin
                        rsp_status_d = ST_OK;
                        if (!we_q) rsp_dat_d = dat_i;
                    end
                    else if (rty_i) rsp_status_d = ST_RTY;
                    else            rsp_status_d = ST_TMO;
                end else if (rty_i) begin
                    rty_d   = rty_q + 1'b1;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    state_d = S_BACKOFF;
                end
            end
            S_BACKOFF: begin
                tmo_d   = '0;
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                state_d = S_BUS;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready  = (state_q == S_IDLE) && !rst_i;
    assign cyc_o      = cyc_q;
    assign stb_o      = stb_q;
    assign we_o       = we_q;
    assign adr_o      = adr_q;
    assign dat_o      = dat_q;
    assign sel_o      = sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dat    = rsp_dat_q;
    assign rsp_status = rsp_status_q;

`ifdef FORMAL
    a_stb_cyc: assert property (@(posedge clk_i) disable iff (rst_i) stb_o |-> cyc_o);
    a_payload: assert property (@(posedge clk_i) disable iff (rst_i)
        stb_o && $past(stb_o) |-> $stable({we_o, adr_o, dat_o, sel_o}));
    a_rsp_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_valid && !rsp_ready |=> rsp_valid && $stable({rsp_dat, rsp_status}));
    a_bus_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        state_q == S_BUS |-> tmo_q < TMO_MAX);
`endif
endmodule

// File: tb/tb_wishbone_classic_cmd_controller.sv
// Directed bench for wishbone_classic_cmd_controller with default parameters
// (32-bit bus, MAX_RETRIES=3, TIMEOUT_CYCLES=16). Inputs change 1ns after the
// rising edge and outputs are sampled there too.
module tb_wishbone_classic_cmd_controller;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i, err_i, rty_i;

    int checks   = 0;
    int failures = 0;

    wishbone_classic_cmd_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_status(rsp_status),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Handshake a command; returns in the first BUS cycle.
    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        chk("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop", rsp_valid, 0);
        chk("back_idle", cmd_ready, 1);
    endtask

    initial begin
        int n, c;
        rst_i = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0;
        rsp_ready = 0; dat_i = 0; ack_i = 0; err_i = 0; rty_i = 0;
        repeat (3) tick();
        chk("rst_cyc", cyc_o, 0);
        chk("rst_stb", stb_o, 0);
        chk("rst_we", we_o, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_payload", {adr_o, dat_o}, 0);
        chk("rst_sel", sel_o, 0);
        chk("rst_rsp", {rsp_dat, rsp_status}, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst_i = 1'b0;
        #1;
        chk("cmd_ready_after_rst", cmd_ready, 1);

        // Write, zero-wait-state ack.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("wr_stb", {cyc_o, stb_o, we_o}, 3'b111);
        chk("wr_adr", adr_o, 32'h10);
        chk("wr_dat", dat_o, 32'hDEADBEEF);
        chk("wr_sel", sel_o, 4'hF);
        chk("wr_no_rsp_yet", rsp_valid, 0);
        n = 0;
        ack_i = 1'b1; n += int'(stb_o); tick(); ack_i = 1'b0; n += int'(stb_o);
        chk("wr_stb_cycles", n, 1);
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_status", rsp_status, 2'b00);
        chk("wr_rsp_dat", rsp_dat, 0);
        finish_rsp();

        // Read with 3 wait states, then back-pressure the response for 5 cycles.
        issue(1'b0, 32'h20, 32'h0, 4'hF);
        chk("rd_we", we_o, 0);
        chk("rd_adr", adr_o, 32'h20);
        dat_i = 32'h12345678; n = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ack_i = 1'b1;
            n += int'(stb_o);
            tick();
        end
        ack_i = 1'b0; dat_i = 32'h0; n += int'(stb_o);
        chk("rd_stb_cycles", n, 4);
        chk("rd_rsp_dat", rsp_dat, 32'h12345678);
        chk("rd_status", rsp_status, 2'b00);
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", rsp_valid, 1);
            chk("bp_dat", rsp_dat, 32'h12345678);
            chk("bp_status", rsp_status, 2'b00);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_no_bus", cyc_o, 0);
            tick();
        end
        cmd_valid = 1'b0;
        finish_rsp();

        // Two retries then ack.
        issue(1'b1, 32'h30, 32'hA5A5A5A5, 4'h3);
        for (int k = 0; k < 2; k++) begin
            chk("rt_stb_on", stb_o, 1);
            rty_i = 1'b1; tick(); rty_i = 1'b0;
            chk("rt_gap", {cyc_o, stb_o}, 2'b00);
            chk("rt_gap_adr", adr_o, 32'h30);
            chk("rt_gap_rsp", rsp_valid, 0);
            tick();
        end
        chk("rt_stb_again", stb_o, 1);
        chk("rt_adr_kept", {adr_o, dat_o}, {32'h30, 32'hA5A5A5A5});
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        chk("rt_rsp_valid", rsp_valid, 1);
        chk("rt_status", rsp_status, 2'b00);
        finish_rsp();

        // Retry on every attempt: 4 attempts, then RETRY_EXHAUSTED.
        issue(1'b0, 32'h40, 32'h0, 4'hF);
        dat_i = 32'h55AA55AA;
        for (int k = 0; k < 4; k++) begin
            chk("rx_attempt_stb", stb_o, 1);
            rty_i = 1'b1; tick(); rty_i = 1'b0;
            if (k < 3) begin
                chk("rx_backoff", stb_o, 0);
                chk("rx_backoff_rsp", rsp_valid, 0);
                tick();
            end
        end
        dat_i = 32'h0;
        chk("rx_rsp_valid", rsp_valid, 1);
        chk("rx_status", rsp_status, 2'b10);
        chk("rx_rsp_dat", rsp_dat, 0);
        finish_rsp();

        // Device silent: timeout after exactly 16 strobe cycles.
        issue(1'b0, 32'h50, 32'h0, 4'hF);
        n = 0; c = 0;
        while (!rsp_valid && c < 40) begin
            n += int'(stb_o); c++;
            tick();
        end
        chk("to_bound", (c < 40), 1);
        chk("to_stb_cycles", n, 16);
        chk("to_stb_low", stb_o, 0);
        chk("to_status", rsp_status, 2'b11);
        chk("to_rsp_dat", rsp_dat, 0);
        finish_rsp();

        // Ack in the last allowed cycle beats the timeout.
        issue(1'b0, 32'h60, 32'h0, 4'hF);
        dat_i = 32'hCAFEF00D;
        repeat (15) tick();
        chk("last_stb", stb_o, 1);
        ack_i = 1'b1; tick(); ack_i = 1'b0; dat_i = 32'h0;
        chk("last_status", rsp_status, 2'b00);
        chk("last_rsp_dat", rsp_dat, 32'hCAFEF00D);
        finish_rsp();

        // err + ack on a read: ERR, data forced to zero.
        issue(1'b0, 32'h70, 32'h0, 4'hF);
        dat_i = 32'hFFFF0000; ack_i = 1'b1; err_i = 1'b1;
        tick();
        ack_i = 1'b0; err_i = 1'b0; dat_i = 32'h0;
        chk("ea_status", rsp_status, 2'b01);
        chk("ea_rsp_dat", rsp_dat, 0);
        finish_rsp();

        // ack + rty: OK.
        issue(1'b0, 32'h80, 32'h0, 4'hF);
        dat_i = 32'h11223344; ack_i = 1'b1; rty_i = 1'b1;
        tick();
        ack_i = 1'b0; rty_i = 1'b0; dat_i = 32'h0;
        chk("ar_status", rsp_status, 2'b00);
        chk("ar_rsp_dat", rsp_dat, 32'h11223344);
        finish_rsp();

        // Terminations outside BUS are ignored.
        ack_i = 1'b1; err_i = 1'b1;
        tick(); tick();
        ack_i = 1'b0; err_i = 1'b0;
        chk("idle_ack_rsp", rsp_valid, 0);
        chk("idle_ack_cyc", cyc_o, 0);
        chk("idle_ack_ready", cmd_ready, 1);

        // Reset pulsed mid-BUS.
        issue(1'b1, 32'h90, 32'h0BADF00D, 4'hF);
        chk("mr_cyc_before", cyc_o, 1);
        rst_i = 1'b1;
        #1;
        chk("mr_cyc_now", {cyc_o, stb_o}, 2'b00);
        chk("mr_cmd_ready", cmd_ready, 0);
        chk("mr_payload", adr_o, 0);
        ack_i = 1'b1;
        tick(); tick();
        chk("mr_no_rsp", rsp_valid, 0);
        ack_i = 1'b0;
        rst_i = 1'b0;
        tick();
        chk("mr_ready_after", cmd_ready, 1);
        chk("mr_no_rsp_after", rsp_valid, 0);
        chk("mr_cyc_after", cyc_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wishbone_classic_cmd_controller.md
# wishbone_classic_cmd_controller

Wishbone classic controller that turns a single-entry valid/ready command stream into single read/write bus cycles. It retries on `rty_i` up to a bound and aborts hung cycles with a timeout. It sits directly upstream of any Wishbone classic device, including the formal fake-device stub. Completed transfers come back as a valid/ready response stream with a status code.

## Interface
- `ADR_WIDTH`, 32, address width.
- `DAT_WIDTH`, 32, data width; multiple of 8.
- `MAX_RETRIES`, 3, re-attempts allowed after `rty_i` (0 = none).
- `TIMEOUT_CYCLES`, 16, per-attempt cycles with `stb_o` high before abort; ≥1.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_we` in 1: 1 = write.
- `cmd_adr` in ADR_WIDTH: address.
- `cmd_dat` in DAT_WIDTH: write data.
- `cmd_sel` in DAT_WIDTH/8: byte selects.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_dat` out DAT_WIDTH: read data.
- `rsp_status` out 2: 00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT.
- `cyc_o`, `stb_o`, `we_o` out 1: bus controls.
- `adr_o` out ADR_WIDTH, `dat_o` out DAT_WIDTH, `sel_o` out DAT_WIDTH/8: bus payload.
- `dat_i` in DAT_WIDTH, `ack_i`, `err_i`, `rty_i` in 1: device response.

## Operation
- States:
  - IDLE: `cmd_ready`=1. A handshake latches `we`/`adr`/`dat`/`sel`, clears the retry count and goes to BUS.
  - BUS: `cyc_o`=`stb_o`=1 and payload driven from the latches. Per cycle, priority is `err_i` > `ack_i` > `rty_i` > timeout.
    - `err_i`: status ERR, go to RESP.
    - `ack_i`: status OK; on reads capture `dat_i` into `rsp_dat`; go to RESP.
    - `rty_i`: if retry count < MAX_RETRIES, increment it and go to BACKOFF. Otherwise status RETRY_EXHAUSTED, go to RESP.
    - Timeout: status TIMEOUT, go to RESP.
  - BACKOFF: one cycle with `cyc_o`=`stb_o`=0, then back to BUS. The payload is unchanged and the timeout counter is cleared.
  - RESP: `rsp_valid`=1 with stable `rsp_dat`/`rsp_status`. `rsp_ready`=1 returns to IDLE.
- `rsp_dat` = 0 for writes and for any non-OK status.
- `cmd_ready`=0 outside IDLE and while `rst_i` is high. There is no command queueing.
- All outputs are registered except `cmd_ready`, which decodes the state register.
- Timeout counter: $clog2(TIMEOUT_CYCLES+1) bits, saturating. It clears at every BUS entry.
- Retry counter: $clog2(MAX_RETRIES+1) bits, never wraps.
- Reset (async, any state): state IDLE; `cyc_o`, `stb_o`, `we_o`, `rsp_valid` = 0; `adr_o`, `dat_o`, `sel_o`, `rsp_dat`, `rsp_status` = 0.
  - A bus cycle in progress is dropped immediately; no response is issued for it.
- Inputs `ack_i`/`err_i`/`rty_i` are ignored outside BUS.
- Formal properties (under `FORMAL`):
  - `stb_o` implies `cyc_o`.
  - Payload is stable while `stb_o` is high.
  - `rsp_valid` is held with stable data until the handshake.
  - BUS never exceeds TIMEOUT_CYCLES consecutive cycles.

## Timing
- Command handshake at edge N: `cyc_o`/`stb_o` high from cycle N+1.
- Termination sampled at edge M: `cyc_o`/`stb_o` low and `rsp_valid` high from cycle M+1.
- Zero-wait-state device: handshake at N, ack sampled at N+1, `rsp_valid` from N+2.
- Earliest next command handshake: the cycle after the response handshake (IDLE for ≥1 cycle).
- Retry: `rty_i` at edge M; BACKOFF in cycle M+1; `stb_o` high again in cycle M+2.
- Timeout: attempt starting cycle S with no termination through cycle S+TIMEOUT_CYCLES-1.
  - `stb_o` low and `rsp_valid`=1 (TIMEOUT) in cycle S+TIMEOUT_CYCLES.
  - A termination in the last cycle S+TIMEOUT_CYCLES-1 wins over the timeout.
- Simultaneous `err_i`+`ack_i`: ERR. Simultaneous `ack_i`+`rty_i`: OK.

## Test plan
- Write 0xDEADBEEF to 0x10, sel 4'hF, device acks on its first cycle.
  - Required: `we_o`=1 for exactly 1 cycle of `stb_o`; `rsp_valid` 2 cycles after the handshake; status 00; `rsp_dat`=0.
- Read from 0x20 with 3 wait states, `dat_i`=0x12345678.
  - Required: `stb_o` high 4 cycles; `rsp_dat`=0x12345678; status 00.
- Device asserts `rty_i` twice, then `ack_i` (MAX_RETRIES=3).
  - Required: two 1-cycle `stb_o` gaps; unchanged address; status 00.
- Device asserts `rty_i` on every attempt.
  - Required: 4 attempts total; status 10.
- Device never responds (TIMEOUT_CYCLES=16).
  - Required: `stb_o` high exactly 16 cycles; status 11.
- `rsp_ready` held low 5 cycles, then high; separately, `rst_i` pulsed mid-BUS.
  - Required: response stable for the 5 cycles and `cmd_ready`=0 throughout.
  - Required: on reset, `cyc_o`=0 immediately; no `rsp_valid`; `cmd_ready`=1 the cycle after `rst_i` falls.
